// File: rtl/sd_reg_arb_pkg.sv
// sd_reg_arb_pkg: shared types and constants for the SD host register-bank arbiter.
//   state_t     : arbiter FSM state encoding
//   REQ_A/REQ_B : requester ids (A = host bus, B = SD core)
//   DEFAULT_DW  : default register data width
package sd_reg_arb_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic REQ_A      = 1'b0;
    localparam logic REQ_B      = 1'b1;
    localparam int   DEFAULT_DW = 32;
endpackage

// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if: one requester's write handshake into the register-bank arbiter.
//   req/addr/wdata : requester -> arbiter (held until gnt, req dropped on done/err)
//   gnt/done/err   : arbiter -> requester, single-cycle pulses
// Modports: master = requester side, slave = arbiter side.
interface reg_bank_arbiter_if import sd_reg_arb_pkg::*; #(
    parameter int AW = 3,
    parameter int DW = DEFAULT_DW
);
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          done;
    logic          err;

    modport master (output req, addr, wdata, input  gnt, done, err);
    modport slave  (input  req, addr, wdata, output gnt, done, err);
endinterface

// File: rtl/reg_arb_pick.sv
// reg_arb_pick: 2-way requester picker.
//   clk, reset : clock, synchronous active-high reset
//   req_a/b    : pending requests
//   adv        : a grant is being taken this cycle (moves the round-robin pointer)
//   sel        : chosen side (REQ_A / REQ_B), only meaningful when a request is pending
// Config macro REG_ARB_RR_EN: defined -> round-robin with a pointer flop that moves to the
// side opposite the winner on every grant; undefined -> fixed priority, A wins ties.
module reg_arb_pick import sd_reg_arb_pkg::*; (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic adv,
    output logic sel
);
`ifdef REG_ARB_RR_EN
    logic ptr;

    always_ff @(posedge clk) begin
        if (reset)    ptr <= REQ_A;
        else if (adv) ptr <= ~sel;
    end

    always_comb begin
        if (req_a && req_b) sel = ptr;
        else                sel = req_a ? REQ_A : REQ_B;
    end
`else
    // Fixed priority needs no state; clock/reset/adv are intentionally unused here.
    logic unused_pick;
    assign unused_pick = ^{clk, reset, adv, req_b};
    assign sel = req_a ? REQ_A : REQ_B;
`endif
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shares write access to the SD host register bank between port A (host bus)
// and port B (SD core). Latches the winner's addr/data, issues a one-cycle one-hot strobe,
// checks the readback the cycle after, rewrites up to MAX_RETRY times, then pulses done or err.
//   clk, reset          : clock, synchronous active-high reset (also aborts a transaction)
//   a_port, b_port      : requester handshakes (reg_bank_arbiter_if.slave)
//   reg_wr_valid        : one-hot write strobe to the bank
//   reg_wr_data         : write data to the bank
//   reg_rd_data         : flattened readback, register i at [i*DW +: DW]
//   reg_ack             : per-register acknowledge
// Config macro REG_ARB_RR_EN (in reg_arb_pick): round-robin tie-break instead of A-priority.
module reg_bank_arbiter import sd_reg_arb_pkg::*; #(
    parameter int NREG      = 8,
    parameter int AW        = 3,
    parameter int DW        = DEFAULT_DW,
    parameter int MAX_RETRY = 2
)(
    input  logic                 clk,
    input  logic                 reset,
    reg_bank_arbiter_if.slave    a_port,
    reg_bank_arbiter_if.slave    b_port,
    output logic [NREG-1:0]      reg_wr_valid,
    output logic [DW-1:0]        reg_wr_data,
    input  logic [NREG*DW-1:0]   reg_rd_data,
    input  logic [NREG-1:0]      reg_ack
);
    localparam int              RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0]   RMAX   = RW'(MAX_RETRY);
    localparam logic [AW:0]     NREG_W = NREG[AW:0];

    state_t        state_q, state_d;
    logic          win_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [RW-1:0] retry_q;

    logic          any_req, take, sel, addr_ok, ack_sel, rd_match, in_write, gnt;
    logic [DW-1:0] rd_sel;

    assign any_req = a_port.req | b_port.req;
    assign take    = (state_q == S_IDLE) && any_req;
    // Addresses past the populated bank are rejected without touching the bank.
    assign addr_ok = {1'b0, addr_q} < NREG_W;

    reg_arb_pick u_pick (
        .clk   (clk),
        .reset (reset),
        .req_a (a_port.req),
        .req_b (b_port.req),
        .adv   (take),
        .sel   (sel)
    );

    // Readback select by loop so an out-of-range address never indexes past the bus.
    always_comb begin
        rd_sel  = '0;
        ack_sel = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_q == AW'(i)) begin
                rd_sel  = reg_rd_data[i*DW +: DW];
                ack_sel = reg_ack[i];
            end
        end
    end
    assign rd_match = ack_sel && (rd_sel == data_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_WRITE;
            S_WRITE: state_d = addr_ok ? S_CHECK : S_ERR;
            S_CHECK: begin
                if (rd_match)           state_d = S_DONE;
                else if (retry_q < RMAX) state_d = S_WRITE;
                else                    state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            win_q   <= REQ_A;
            addr_q  <= '0;
            data_q  <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                win_q   <= sel;
                addr_q  <= (sel == REQ_A) ? a_port.addr  : b_port.addr;
                data_q  <= (sel == REQ_A) ? a_port.wdata : b_port.wdata;
                retry_q <= '0;
            end
            if (state_q == S_CHECK && !rd_match && retry_q < RMAX)
                retry_q <= retry_q + 1'b1;
            if (state_q == S_DONE || state_q == S_ERR)
                retry_q <= '0;
        end
    end

    // retry_q is zero only on the first WRITE of a transaction, so gnt pulses once.
    assign in_write = (state_q == S_WRITE);
    assign gnt      = in_write && (retry_q == '0);

    assign a_port.gnt  = gnt && (win_q == REQ_A);
    assign b_port.gnt  = gnt && (win_q == REQ_B);
    assign a_port.done = (state_q == S_DONE) && (win_q == REQ_A);
    assign b_port.done = (state_q == S_DONE) && (win_q == REQ_B);
    assign a_port.err  = (state_q == S_ERR)  && (win_q == REQ_A);
    assign b_port.err  = (state_q == S_ERR)  && (win_q == REQ_B);

    always_comb begin
        reg_wr_valid = '0;
        for (int i = 0; i < NREG; i++)
            reg_wr_valid[i] = in_write && addr_ok && (addr_q == AW'(i));
    end
    assign reg_wr_data = (in_write && addr_ok) ? data_q : '0;
endmodule
